// File: rtl/fpu_mult_param.sv
// Parameterised IEEE-style floating-point multiplier with a 3-stage valid/ready pipeline.
// Subnormals flush to zero; rounding is round-to-nearest-even; one global stall enable.
module fpu_mult_param #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int SW = EXP_W + 2;
    localparam int PW = 2 * (MAN_W + 1);
    localparam logic [EXP_W-1:0]        EXP_ONES = '1;
    localparam logic signed [SW-1:0]    BIAS     = SW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [SW-1:0]    EXP_MAX  = SW'((1 << EXP_W) - 1);
    localparam logic signed [SW-1:0]    EXP_ZERO = '0;
    localparam logic [FW-1:0]           QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic en_s;

    // S1: unpack/classify registers
    logic                 s1_valid_r, s1_sign_r, s1_special_r;
    logic [EXP_W-1:0]     s1_exp_a_r, s1_exp_b_r;
    logic [MAN_W:0]       s1_man_a_r, s1_man_b_r;
    logic [FW-1:0]        s1_spec_res_r;
    logic [3:0]           s1_spec_flags_r;
    // S2: multiply/exponent-sum registers
    logic                 s2_valid_r, s2_sign_r, s2_special_r;
    logic signed [SW-1:0] s2_exp_r;
    logic [PW-1:0]        s2_prod_r;
    logic [FW-1:0]        s2_spec_res_r;
    logic [3:0]           s2_spec_flags_r;
    // S3: packed result registers
    logic                 s3_valid_r;
    logic [FW-1:0]        s3_res_r;
    logic [3:0]           s3_flags_r;

    assign en_s      = !s3_valid_r || out_ready;
    assign in_ready  = en_s;
    assign out_valid = s3_valid_r;
    assign result    = 32'(s3_res_r);
    assign flags     = s3_flags_r;

    // S1 combinational: field extraction and special-operand resolution
    logic                 sign_a_s, sign_b_s;
    logic [EXP_W-1:0]     exp_a_s, exp_b_s;
    logic [MAN_W-1:0]     man_a_s, man_b_s;
    logic                 zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s, snan_a_s, snan_b_s;
    logic                 special_s;
    logic [FW-1:0]        spec_res_s;
    logic [3:0]           spec_flags_s;

    assign sign_a_s = a[FW-1];
    assign sign_b_s = b[FW-1];
    assign exp_a_s  = a[FW-2:MAN_W];
    assign exp_b_s  = b[FW-2:MAN_W];
    assign man_a_s  = a[MAN_W-1:0];
    assign man_b_s  = b[MAN_W-1:0];
    assign zero_a_s = (exp_a_s == '0);
    assign zero_b_s = (exp_b_s == '0);
    assign inf_a_s  = (exp_a_s == EXP_ONES) && (man_a_s == '0);
    assign inf_b_s  = (exp_b_s == EXP_ONES) && (man_b_s == '0);
    assign nan_a_s  = (exp_a_s == EXP_ONES) && (man_a_s != '0);
    assign nan_b_s  = (exp_b_s == EXP_ONES) && (man_b_s != '0);
    assign snan_a_s = nan_a_s && !man_a_s[MAN_W-1];
    assign snan_b_s = nan_b_s && !man_b_s[MAN_W-1];

    // Special-case priority: NaN / invalid, then infinity, then zero (subnormals count as zero)
    always_comb begin
        special_s    = 1'b0;
        spec_res_s   = '0;
        spec_flags_s = 4'b0000;
        if (nan_a_s || nan_b_s || (inf_a_s && zero_b_s) || (zero_a_s && inf_b_s)) begin
            special_s    = 1'b1;
            spec_res_s   = QNAN;
            spec_flags_s = {((inf_a_s && zero_b_s) || (zero_a_s && inf_b_s) || snan_a_s || snan_b_s),
                            3'b000};
        end else if (inf_a_s || inf_b_s) begin
            special_s    = 1'b1;
            spec_res_s   = {sign_a_s ^ sign_b_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (zero_a_s || zero_b_s) begin
            special_s    = 1'b1;
            spec_res_s   = {sign_a_s ^ sign_b_s, {(FW-1){1'b0}}};
        end else begin
            special_s    = 1'b0;
        end
    end

    // S2 combinational: significand product and unbiased-sum exponent
    logic [PW-1:0]        prod_s;
    logic signed [SW-1:0] exp_sum_s;

    assign prod_s    = PW'(s1_man_a_r) * PW'(s1_man_b_r);
    assign exp_sum_s = $signed({2'b00, s1_exp_a_r}) + $signed({2'b00, s1_exp_b_r}) - BIAS;

    // S3 combinational: normalise, round to nearest even, range check and pack
    logic [PW-2:0]        norm_s;
    logic [MAN_W-1:0]     mant_s;
    logic                 guard_s, sticky_s, round_up_s;
    logic [MAN_W:0]       mant_rnd_s;
    logic signed [SW-1:0] exp_fin_s;
    logic [FW-1:0]        res_s;
    logic [3:0]           flags_s;

    assign norm_s     = s2_prod_r[PW-1] ? s2_prod_r[PW-1:1] : s2_prod_r[PW-2:0];
    assign mant_s     = norm_s[PW-3 -: MAN_W];
    assign guard_s    = norm_s[PW-3-MAN_W];
    assign sticky_s   = (|norm_s[PW-4-MAN_W:0]) || (s2_prod_r[PW-1] && s2_prod_r[0]);
    assign round_up_s = guard_s && (sticky_s || mant_s[0]);
    assign mant_rnd_s = {1'b0, mant_s} + (MAN_W+1)'(round_up_s);
    assign exp_fin_s  = s2_exp_r + $signed({{(SW-1){1'b0}}, s2_prod_r[PW-1]})
                                 + $signed({{(SW-1){1'b0}}, mant_rnd_s[MAN_W]});

    // Final result selection for the S3 register
    always_comb begin
        res_s   = '0;
        flags_s = 4'b0000;
        if (s2_special_r) begin
            res_s   = s2_spec_res_r;
            flags_s = s2_spec_flags_r;
        end else if (exp_fin_s >= EXP_MAX) begin
            res_s   = {s2_sign_r, EXP_ONES, {MAN_W{1'b0}}};
            flags_s = 4'b0101;
        end else if (exp_fin_s <= EXP_ZERO) begin
            res_s   = {s2_sign_r, {(FW-1){1'b0}}};
            flags_s = 4'b0011;
        end else begin
            res_s   = {s2_sign_r, exp_fin_s[EXP_W-1:0], mant_rnd_s[MAN_W-1:0]};
            flags_s = {3'b000, guard_s || sticky_s};
        end
    end

    logic unused_s;
    assign unused_s = norm_s[PW-2];
    if (FW < 32) begin : g_unused_hi
        logic unused_hi_s;
        assign unused_hi_s = ^{a[31:FW], b[31:FW]};
    end

    // Pipeline registers: synchronous reset clears valids and outputs, all stages hold on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r      <= 1'b0;
            s2_valid_r      <= 1'b0;
            s3_valid_r      <= 1'b0;
            s3_res_r        <= '0;
            s3_flags_r      <= 4'b0000;
            s1_sign_r       <= 1'b0;
            s1_special_r    <= 1'b0;
            s1_exp_a_r      <= '0;
            s1_exp_b_r      <= '0;
            s1_man_a_r      <= '0;
            s1_man_b_r      <= '0;
            s1_spec_res_r   <= '0;
            s1_spec_flags_r <= 4'b0000;
            s2_sign_r       <= 1'b0;
            s2_special_r    <= 1'b0;
            s2_exp_r        <= '0;
            s2_prod_r       <= '0;
            s2_spec_res_r   <= '0;
            s2_spec_flags_r <= 4'b0000;
        end else if (en_s) begin
            s1_valid_r      <= in_valid;
            s1_sign_r       <= sign_a_s ^ sign_b_s;
            s1_special_r    <= special_s;
            s1_exp_a_r      <= exp_a_s;
            s1_exp_b_r      <= exp_b_s;
            s1_man_a_r      <= {1'b1, man_a_s};
            s1_man_b_r      <= {1'b1, man_b_s};
            s1_spec_res_r   <= spec_res_s;
            s1_spec_flags_r <= spec_flags_s;

            s2_valid_r      <= s1_valid_r;
            s2_sign_r       <= s1_sign_r;
            s2_special_r    <= s1_special_r;
            s2_exp_r        <= exp_sum_s;
            s2_prod_r       <= prod_s;
            s2_spec_res_r   <= s1_spec_res_r;
            s2_spec_flags_r <= s1_spec_flags_r;

            s3_valid_r      <= s2_valid_r;
            s3_res_r        <= res_s;
            s3_flags_r      <= flags_s;
        end
    end
endmodule

// File: doc/fpu_mult_param.md
FPU_MULT_PARAM -- requirements
Module: fpu_mult_param

Interface
REQ-001 Parameter EXP_W, default 5: exponent field width; legal range 3..8.
REQ-002 Parameter MAN_W, default 10: stored mantissa width; legal range 2..23; 1+EXP_W+MAN_W SHALL be <= 32.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port in_valid  input  1: operand pair a/b is presented.
REQ-006 Port in_ready  output  1: block accepts the pair this cycle.
REQ-007 Port a  input  32: operand A in bits [FW-1:0], FW = 1+EXP_W+MAN_W; upper bits ignored.
REQ-008 Port b  input  32: operand B, same packing as a.
REQ-009 Port out_valid  output  1: result and flags are valid.
REQ-010 Port out_ready  input  1: consumer takes the result this cycle.
REQ-011 Port result  output  32: product in bits [FW-1:0]; bits [31:FW] SHALL be zero.
REQ-012 Port flags  output  4: {invalid, overflow, underflow, inexact} for the result.

Function
REQ-013 Transfer: input on in_valid & in_ready; output on out_valid & out_ready.
REQ-014 Pipeline: 3 register stages (S1 unpack/classify, S2 mantissa multiply and exponent sum, S3 normalise/round/pack); an accepted pair appears at out_valid exactly 3 cycles later if never stalled.
REQ-015 Stall: global enable en = !out_valid | out_ready; in_ready = en; when en is 0 every stage holds its contents.
REQ-016 Capacity: up to 3 operations in flight; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-017 Bubbles: S1/S2/S3 carry a valid bit; an invalid slot never raises out_valid.
REQ-018 Bias = 2^(EXP_W-1)-1; exponent arithmetic SHALL use EXP_W+2 signed bits so no intermediate wraps.
REQ-019 Subnormal inputs (exp=0, man!=0) SHALL be treated as signed zero (flush-to-zero), no flag.
REQ-020 Sign = sign_a XOR sign_b for all non-NaN results.
REQ-021 NaN: either input NaN, or inf x zero -> canonical quiet NaN {0, all-ones exp, 1 followed by MAN_W-1 zeros}; invalid=1 only for inf x zero or signalling NaN input (mantissa MSB 0).
REQ-022 Inf x finite nonzero, or inf x inf -> signed infinity, no flags.
REQ-023 Zero x finite -> signed zero, no flags.
REQ-024 Normal path: (MAN_W+1)x(MAN_W+1) product; if top bit set shift right 1 and exponent +1.
REQ-025 Rounding: round-to-nearest-even using guard bit and sticky OR of all lower bits; inexact=1 when guard|sticky.
REQ-026 Rounding carry-out SHALL renormalise (mantissa 0, exponent +1).
REQ-027 Overflow: final biased exponent >= 2^EXP_W-1 -> signed infinity, overflow=1, inexact=1.
REQ-028 Underflow: final biased exponent <= 0 -> signed zero (no subnormal output), underflow=1, inexact=1.
REQ-029 result and flags SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-030 When rst=1 at a clock edge all valid bits SHALL clear; out_valid=0, result=0, flags=0 after that edge.
REQ-031 in_ready SHALL be 1 the cycle after reset deasserts; operations in flight at reset are discarded and never emitted.
REQ-032 rst SHALL take priority over in_valid in the same cycle; that pair is not accepted.

Verification (default EXP_W=5, MAN_W=10)
REQ-033 a=0x3C00, b=0x3C00, out_ready=1 -> result 0x00003C00, flags 0, out_valid exactly 3 cycles after acceptance.
REQ-034 a=0x3C01, b=0x3C01 -> result 0x3C02, flags 0001 (inexact); a=0x7BFF, b=0x7BFF -> 0x7C00, flags 0101.
REQ-035 a=0x7C00, b=0x0000 -> 0x7E00, flags 1000; a=0xFC00, b=0x4000 -> 0xFC00, flags 0; a=0x0400, b=0x0400 -> 0x0000, flags 0011.
REQ-036 out_ready=0 for 6 cycles while in_valid=1 with 5 distinct pairs -> exactly 3 accepted, in_ready=0 thereafter; on out_ready=1 all 5 results emerge in order, none lost.
REQ-037 rst=1 for 1 cycle with 2 operations in flight -> out_valid=0 next cycle, neither result ever emitted; next accepted pair returns after 3 cycles.
REQ-038 EXP_W=8, MAN_W=23 build: a=0x3F800000, b=0x40000000 -> result 0x40000000, flags 0.
